// File: rtl/fir_cfg_master.sv
// fir_cfg_master: AXI-lite master that loads FIR length, tap count and coefficients,
// verifies them by readback, then starts the engine and polls for ap_done.
module fir_cfg_master #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int pPOLL_LIMIT = 4096
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst,
   input  logic                   cfg_start,
   input  logic [31:0]            cfg_data_length,
   input  logic [5:0]             cfg_tap_num,
   output logic [4:0]             coef_idx,
   input  logic [31:0]            coef_data,
   output logic                   awvalid,
   input  logic                   awready,
   output logic [pADDR_WIDTH-1:0] awaddr,
   output logic                   wvalid,
   input  logic                   wready,
   output logic [pDATA_WIDTH-1:0] wdata,
   output logic                   arvalid,
   input  logic                   arready,
   output logic [pADDR_WIDTH-1:0] araddr,
   input  logic                   rvalid,
   output logic                   rready,
   input  logic [pDATA_WIDTH-1:0] rdata,
   output logic                   busy,
   output logic                   done,
   output logic                   mismatch,
   output logic                   timeout
);
   localparam int CW = $clog2(pPOLL_LIMIT + 1);
   typedef enum logic [3:0] {IDLE, WR_LEN, WR_TAP, WR_COEF, RD_LEN, RD_TAP, RD_COEF, WR_START, POLL, DONE} state_t;
   state_t state, state_nxt;
   logic [31:0] len_r;
   logic [5:0] tap_r, tap_in;
   logic act, wr_st, rd_st, wr_end, rd_end, last, poll_last, is_len, is_tap, is_coef;
   logic [1:0] gap;
   logic [CW-1:0] poll_cnt;
   logic [pADDR_WIDTH-1:0] cur_addr;
   logic [pDATA_WIDTH-1:0] cur_data;

   always_comb begin
      tap_in = cfg_tap_num == 6'd0 ? 6'd1 : cfg_tap_num > 6'd32 ? 6'd32 : cfg_tap_num;
      is_len = state inside {WR_LEN, RD_LEN};
      is_tap = state inside {WR_TAP, RD_TAP};
      is_coef = state inside {WR_COEF, RD_COEF};
      wr_st = state inside {WR_LEN, WR_TAP, WR_COEF, WR_START};
      rd_st = state inside {RD_LEN, RD_TAP, RD_COEF, POLL};
      // a write completes once each channel has either finished or is finishing now
      wr_end = act && wr_st && (!awvalid || awready) && (!wvalid || wready);
      rd_end = act && rd_st && rvalid && rready;
      last = {1'b0, coef_idx} == tap_r - 6'd1;
      poll_last = poll_cnt == CW'(pPOLL_LIMIT - 1);
      cur_addr = is_len ? pADDR_WIDTH'(8'h10) : is_tap ? pADDR_WIDTH'(8'h14) :
                 is_coef ? pADDR_WIDTH'(8'h80 + {1'b0, coef_idx, 2'b00}) : '0;
      cur_data = is_len ? pDATA_WIDTH'(len_r) : is_tap ? pDATA_WIDTH'(tap_r) :
                 is_coef ? pDATA_WIDTH'(coef_data) : pDATA_WIDTH'(1);
      state_nxt = state;
      case (state)
         IDLE:     if (cfg_start) state_nxt = WR_LEN;
         WR_LEN:   if (wr_end) state_nxt = WR_TAP;
         WR_TAP:   if (wr_end) state_nxt = WR_COEF;
         WR_COEF:  if (wr_end && last) state_nxt = RD_LEN;
         RD_LEN:   if (rd_end) state_nxt = RD_TAP;
         RD_TAP:   if (rd_end) state_nxt = RD_COEF;
         RD_COEF:  if (rd_end && last) state_nxt = WR_START;
         WR_START: if (wr_end) state_nxt = POLL;
         POLL:     if (rd_end && (rdata[1] || poll_last)) state_nxt = DONE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge axis_clk or posedge axis_rst)
      if (axis_rst) state <= IDLE;
      else state <= state_nxt;

   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         {awvalid, wvalid, arvalid, rready, busy, done, mismatch, timeout, act} <= '0;
         awaddr <= '0;
         wdata <= '0;
         araddr <= '0;
         coef_idx <= '0;
         len_r <= '0;
         tap_r <= '0;
         gap <= '0;
         poll_cnt <= '0;
      end else begin
         busy <= state_nxt != IDLE && state_nxt != DONE;
         done <= state_nxt == DONE;
         if (state == IDLE && cfg_start) begin
            len_r <= cfg_data_length;
            tap_r <= tap_in;
            mismatch <= 1'b0;
            timeout <= 1'b0;
            poll_cnt <= '0;
            gap <= '0;
         end
         if (wr_st && !act) begin
            act <= 1'b1;
            awvalid <= 1'b1;
            wvalid <= 1'b1;
            awaddr <= cur_addr;
            wdata <= cur_data;
         end
         if (rd_st && !act && gap == 2'd0) begin
            act <= 1'b1;
            arvalid <= 1'b1;
            rready <= 1'b1;
            araddr <= cur_addr;
         end
         if (state == POLL && !act && gap != 2'd0) gap <= gap - 2'd1;
         if (awvalid && awready) begin
            awvalid <= 1'b0;
            awaddr <= '0;
         end
         if (wvalid && wready) begin
            wvalid <= 1'b0;
            wdata <= '0;
         end
         if (arvalid && arready) begin
            arvalid <= 1'b0;
            araddr <= '0;
         end
         if (wr_end) begin
            act <= 1'b0;
            coef_idx <= (state == WR_COEF && !last) ? coef_idx + 5'd1 : 5'd0;
         end
         if (rd_end) begin
            act <= 1'b0;
            rready <= 1'b0;
            arvalid <= 1'b0;
            araddr <= '0;
            if (state != POLL && rdata != cur_data) mismatch <= 1'b1;
            if (state == RD_COEF) coef_idx <= last ? 5'd0 : coef_idx + 5'd1;
            // gap of 3 plus the launch cycle gives four idle cycles between polls
            if (state == POLL) begin
               poll_cnt <= poll_cnt + CW'(1);
               gap <= 2'd3;
               if (poll_last && !rdata[1]) timeout <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fir_cfg_master.sv
// tb_fir_cfg_master: directed bench with an AXI-lite register responder model
// and hand-computed expectations for the programming sequence.
module tb_fir_cfg_master;
   logic axis_clk = 1'b0, axis_rst = 1'b1;
   logic cfg_start = 1'b0;
   logic [31:0] cfg_data_length = '0;
   logic [5:0] cfg_tap_num = '0;
   logic [4:0] coef_idx;
   logic [31:0] coef_data, wdata, rdata;
   logic [11:0] awaddr, araddr;
   logic awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
   logic busy, done, mismatch, timeout;

   always #5 axis_clk = ~axis_clk;

   fir_cfg_master #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pPOLL_LIMIT(8)) dut (
      .axis_clk(axis_clk), .axis_rst(axis_rst), .cfg_start(cfg_start),
      .cfg_data_length(cfg_data_length), .cfg_tap_num(cfg_tap_num),
      .coef_idx(coef_idx), .coef_data(coef_data),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata),
      .busy(busy), .done(done), .mismatch(mismatch), .timeout(timeout));

   int aw_dly = 0, w_dly = 0, done_after = 0;
   int aw_wait = 0, w_wait = 0, poll_n = 0, wonly = 0, viol = 0, dones = 0;
   logic corrupt = 1'b0, clr = 1'b0, r_pend = 1'b0, pa = 1'b0, pw = 1'b0;
   logic [11:0] a_lat = '0, r_addr = '0, paddr = '0;
   logic [31:0] pdata = '0;
   logic [31:0] mem [0:63];
   logic [11:0] aw_q [$];
   logic [11:0] ar_q [$];
   logic [31:0] w_q [$];

   assign awready = awvalid && aw_wait >= aw_dly;
   assign wready = wvalid && w_wait >= w_dly;
   assign arready = arvalid && !r_pend;
   assign rvalid = r_pend;
   // status register reports ap_done (bit 1) once done_after polls have been served
   assign rdata = r_addr == 12'h000 ? (poll_n >= done_after ? 32'h2 : 32'h0)
                : mem[r_addr[7:2]] ^ ((corrupt && r_addr == 12'h084) ? 32'h1 : 32'h0);
   assign coef_data = 32'hC0E0_0000 + 32'(coef_idx) * 32'd17;

   always @(posedge axis_clk) begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait <= (wvalid && !wready) ? w_wait + 1 : 0;
      if (awvalid && awready) begin
         a_lat <= awaddr;
         aw_q.push_back(awaddr);
      end
      if (wvalid && wready) begin
         w_q.push_back(wdata);
         mem[(awvalid && awready) ? awaddr[7:2] : a_lat[7:2]] <= wdata;
      end
      if (arvalid && arready) begin
         r_addr <= araddr;
         r_pend <= 1'b1;
      end
      if (rvalid && rready) begin
         r_pend <= 1'b0;
         ar_q.push_back(r_addr);
         if (r_addr == 12'h000) poll_n <= poll_n + 1;
      end
      if (clr) poll_n <= 0;
      if (axis_rst) r_pend <= 1'b0;
      pa <= awvalid;
      pw <= wvalid;
      paddr <= awaddr;
      pdata <= wdata;
      if (wvalid && !awvalid) wonly <= wonly + 1;
      if ((!awvalid && awaddr != 0) || (!wvalid && wdata != 0) ||
          (awvalid && pa && awaddr != paddr) || (wvalid && pw && wdata != pdata) ||
          ((awvalid && !pa) != (wvalid && !pw)))
         viol <= viol + 1;
   end

   always @(negedge axis_clk) if (done) dones <= dones + 1;

   int n_chk = 0, n_pass = 0;
   int aw0, w0, ar0, wo0, dn0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic go(input logic [31:0] len, input logic [5:0] taps);
      @(negedge axis_clk);
      aw0 = aw_q.size(); w0 = w_q.size(); ar0 = ar_q.size(); wo0 = wonly; dn0 = dones;
      cfg_data_length = len;
      cfg_tap_num = taps;
      cfg_start = 1'b1;
      clr = 1'b1;
      @(negedge axis_clk);
      cfg_start = 1'b0;
      clr = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int c = 0;
      while (!done && c < 3000) begin
         @(negedge axis_clk);
         c++;
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_at_done"}, busy, 0);
      @(negedge axis_clk);
      #1;
      chk({tag, "_done_pulse"}, done, 0);
   endtask

   function automatic int zeros();
      int z = 0;
      for (int i = ar0; i < ar_q.size(); i++) if (ar_q[i] == 12'h000) z++;
      return z;
   endfunction

   initial begin
      #1;
      chk("rst_ctl", {awvalid, wvalid, arvalid, rready, busy, done, mismatch, timeout}, 0);
      chk("rst_bus", {awaddr, wdata, araddr, coef_idx}, 0);
      repeat (2) @(negedge axis_clk);
      axis_rst = 1'b0;

      // basic sequence: 17 taps, immediate responder, ap_done on third poll
      done_after = 2;
      go(500, 17);
      chk("t1_busy", busy, 1);
      wait_done("t1");
      chk("t1_aw_n", aw_q.size() - aw0, 20);
      chk("t1_w_n", w_q.size() - w0, 20);
      chk("t1_len", w_q[w0], 32'd500);
      chk("t1_tap", w_q[w0 + 1], 32'd17);
      chk("t1_aw_c0", aw_q[aw0 + 2], 12'h080);
      chk("t1_aw_c16", aw_q[aw0 + 18], 12'h0C0);
      chk("t1_w_c8", w_q[w0 + 10], 32'hC0E0_0088);
      chk("t1_start_a", aw_q[aw0 + 19], 12'h000);
      chk("t1_start_d", w_q[w0 + 19], 32'h1);
      chk("t1_ar_n", ar_q.size() - ar0, 22);
      chk("t1_ar_c0", ar_q[ar0 + 2], 12'h080);
      chk("t1_ar_c16", ar_q[ar0 + 18], 12'h0C0);
      chk("t1_polls", zeros(), 3);
      chk("t1_mismatch", mismatch, 0);
      chk("t1_timeout", timeout, 0);

      // wready lags awready by three cycles
      w_dly = 3;
      done_after = 0;
      go(7, 2);
      wait_done("t2");
      chk("t2_aw_n", aw_q.size() - aw0, 5);
      chk("t2_w_only_cycles", wonly - wo0, 15);
      chk("t2_mismatch", mismatch, 0);
      w_dly = 0;

      // corrupted readback of 0x84
      corrupt = 1'b1;
      go(9, 4);
      wait_done("t3");
      chk("t3_mismatch", mismatch, 1);
      chk("t3_aw_n", aw_q.size() - aw0, 7);
      chk("t3_ar_n", ar_q.size() - ar0, 7);
      chk("t3_ar_84", ar_q[ar0 + 3], 12'h084);
      chk("t3_start_a", aw_q[aw0 + 6], 12'h000);
      corrupt = 1'b0;

      // ap_done never seen
      done_after = 1000;
      go(5, 1);
      wait_done("t4");
      chk("t4_polls", zeros(), 8);
      chk("t4_timeout", timeout, 1);
      chk("t4_mismatch_clr", mismatch, 0);
      done_after = 0;

      // reset while a coefficient write is outstanding
      aw_dly = 2;
      w_dly = 2;
      go(6, 5);
      begin
         int c = 0;
         while (!(awvalid && awaddr >= 12'h080) && c < 500) begin
            @(negedge axis_clk);
            c++;
         end
      end
      chk("t5_reach", {awvalid, busy}, 2'b11);
      #2 axis_rst = 1'b1;
      #1;
      chk("t5_rst_ctl", {awvalid, wvalid, arvalid, rready, busy, done, mismatch, timeout}, 0);
      chk("t5_rst_bus", {awaddr, wdata, araddr, coef_idx}, 0);
      @(negedge axis_clk);
      axis_rst = 1'b0;
      aw_dly = 0;
      w_dly = 0;
      @(negedge axis_clk);
      chk("t5_idle", {busy, awvalid, wvalid}, 0);
      go(3, 1);
      wait_done("t5");
      chk("t5_first_a", aw_q[aw0], 12'h010);
      chk("t5_aw_n", aw_q.size() - aw0, 4);
      chk("t5_timeout_clr", timeout, 0);

      // 40 taps clamp to 32; a second cfg_start while busy is ignored
      go(42, 40);
      repeat (10) @(negedge axis_clk);
      cfg_data_length = 99;
      cfg_start = 1'b1;
      @(negedge axis_clk);
      cfg_start = 1'b0;
      wait_done("t6");
      chk("t6_aw_n", aw_q.size() - aw0, 35);
      chk("t6_len", w_q[w0], 32'd42);
      chk("t6_tap", w_q[w0 + 1], 32'd32);
      chk("t6_aw_c31", aw_q[aw0 + 33], 12'h0FC);
      chk("t6_dones", dones - dn0, 1);
      chk("t6_mismatch", mismatch, 0);

      // zero taps treated as one
      go(1, 0);
      wait_done("t7");
      chk("t7_aw_n", aw_q.size() - aw0, 4);
      chk("t7_tap", w_q[w0 + 1], 32'd1);

      chk("protocol_violations", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
